lsu_mem_port: RTL and testbench

Load/store port between the single-cycle core and a handshaked data memory. Accepts one load or store per instruction and stalls the core until the memory completes. Performs byte-lane steering, write-enable generation and load sign/zero extension. Its `load_data` output is the memory-data input of the writeback select stage.

---
 rtl/lsu_mem_port.sv | 183 ++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// Load/store port: steers bytes to a handshaked data memory and formats load data for writeback.
// Latency: load 4 cycles minimum, store 3, faulted access 2; the core is stalled until DONE.
// Backpressure: the memory request is held stable until mem_gnt; a watchdog aborts slow accesses.
module lsu_mem_port #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  // Counter value seen in the last cycle the access is allowed to spend in REQ+WAIT.
  localparam bit              WD_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wd_cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             fault_q;

  logic             f3_legal, misaligned;
  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt;
  logic [7:0]       rd_byte;
  logic [15:0]      rd_half;
  logic [31:0]      load_fmt;
  logic             wd_last;
  logic             accept, fault, abort, capture;

  assign wd_last = WD_EN && (wd_cnt == WD_LAST);

  // Classify the incoming request: legal funct3 for its direction, natural alignment.
  always_comb begin
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    if (req_we) f3_legal = (req_funct3 <= 3'd2);
    else        f3_legal = (req_funct3 != 3'd3) && (req_funct3 <= 3'd5);
    case (req_funct3[1:0])
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Store lane replication and byte enables; loads always read the whole word.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = req_wdata;
    if (req_we) begin
      case (req_funct3[1:0])
        2'd0: begin
          be_nxt    = 4'b0001 << req_addr[1:0];
          wdata_nxt = {4{req_wdata[7:0]}};
        end
        2'd1: begin
          be_nxt    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_nxt = {2{req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Pick the addressed byte/half from the returned word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'd0:    load_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'd1:    load_fmt = {{16{rd_half[15]}}, rd_half};
      3'd4:    load_fmt = {24'd0, rd_byte};
      3'd5:    load_fmt = {16'd0, rd_half};
      default: load_fmt = mem_rdata;
    endcase
  end

  // Next state and per-cycle events; completion beats the watchdog in its final cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fault     = 1'b0;
    abort     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (f3_legal && !misaligned) begin
            accept    = 1'b1;
            state_nxt = REQ;
          end else begin
            fault     = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      REQ: begin
        if (mem_gnt && mem_we) begin
          state_nxt = DONE;
        end else if (wd_last) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end else if (mem_gnt) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end else if (wd_last) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall   = ((state == IDLE) && req_valid) || (state == REQ) || (state == WAIT);
  assign mem_req = (state == REQ);
  assign err     = (state == DONE) && fault_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Request registers, fault flag, load result and watchdog counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      fault_q   <= 1'b0;
      load_data <= '0;
      wd_cnt    <= '0;
    end else begin
      if (accept) begin
        mem_we    <= req_we;
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= wdata_nxt;
        mem_be    <= be_nxt;
        f3_q      <= req_funct3;
        off_q     <= req_addr[1:0];
      end
      if (accept)              fault_q <= 1'b0;
      else if (fault || abort) fault_q <= 1'b1;
      if (fault || abort) load_data <= '0;
      else if (capture)   load_data <= load_fmt;
      if (accept)                               wd_cnt <= '0;
      else if ((state == REQ) || (state == WAIT)) wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: transaction-level model of the access timeline and data formatting.
// Latency: one transaction at a time; memory delays chosen per transaction.
// Backpressure: grant and rvalid delays randomized, watchdog set to 4 cycles.
module tb_lsu_mem_port;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, err, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;

  lsu_mem_port #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .load_data(load_data), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic        chk_on = 1'b0;
  logic        e_stall, e_req, e_err, e_mchk, e_we;
  logic [31:0] e_ld, e_addr, e_wdata;
  logic [3:0]  e_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs are set by the stimulus at posedge+1; compared mid-cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("err", 32'(err), 32'(e_err));
      chk("load_data", load_data, e_ld);
      if (e_mchk) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_we", 32'(mem_we), 32'(e_we));
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
    end
  end

  function automatic logic is_fault(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic legal;
    legal = we ? (f3 < 3'd3) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    if (f3 % 4 == 1) return (a % 2) != 0;
    if (f3 % 4 == 2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int v;
    v = 15;
    if (we && f3 == 3'd0) v = 1 << (a % 4);
    if (we && f3 == 3'd1) v = 3 << (a % 4);
    return 4'(v);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3 == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  // One access: gd = REQ cycles without grant, rd = WAIT cycles without rvalid.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rdv, input int gd, input int rd);
    logic flt, tmo;
    int need, n;
    flt = is_fault(we, f3, a);
    tmo = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    mem_rdata = rdv;
    mem_gnt = 1'($urandom % 2); mem_rvalid = 1'($urandom % 2);
    e_stall = 1'b1; e_req = 1'b0; e_err = 1'b0; e_mchk = 1'b0;
    e_we = we; e_addr = a & 32'hFFFF_FFFC; e_be = exp_be(we, f3, a); e_wdata = exp_wdata(f3, wd);
    @(posedge clk); #1;
    if (!flt) begin
      need = we ? gd + 1 : gd + rd + 2;
      n = need;
      if (TO != 0 && need > TO) begin
        n = TO;
        tmo = 1'b1;
      end
      for (int c = 0; c < n; c++) begin
        e_req = (c <= gd); e_mchk = e_req; e_stall = 1'b1;
        mem_gnt = e_req && (c == gd);
        mem_rvalid = e_req ? 1'($urandom % 2) : (c == gd + 1 + rd);
        @(posedge clk); #1;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    e_stall = 1'b0; e_req = 1'b0; e_mchk = 1'b0; e_err = flt | tmo;
    if (flt | tmo) e_ld = '0;
    else if (!we)  e_ld = exp_load(f3, a, rdv);
    @(posedge clk); #1;
    req_valid = 1'b0; e_err = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      req_valid = 1'b0;
      mem_gnt = 1'($urandom % 2); mem_rvalid = 1'($urandom % 2);
      e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0; e_mchk = 1'b0;
      @(posedge clk); #1;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    e_stall = 1'b0; e_req = 1'b0; e_err = 1'b0; e_mchk = 1'b0; e_we = 1'b0;
    e_ld = '0; e_addr = '0; e_wdata = '0; e_be = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    idle(1);

    run_txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    chk("lw_lit", load_data, 32'hDEAD_BEEF);
    chk("lw_addr_lit", mem_addr, 32'h100);
    chk("lw_be_lit", 32'(mem_be), 32'hF);
    idle(1);
    run_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 1, 1);
    chk("lb_lit", load_data, 32'hFFFF_FF80);
    run_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 0, 2);
    chk("lbu_lit", load_data, 32'h0000_0080);
    run_txn(1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF_0000, 0, 0);
    chk("lhu_lit", load_data, 32'h0000_80FF);
    run_txn(1'b1, 3'd0, 32'h205, 32'h1234_5678, 32'h0, 3, 0);
    chk("sb_wdata_lit", mem_wdata, 32'h7878_7878);
    chk("sb_be_lit", 32'(mem_be), 32'h2);
    chk("sb_ld_hold", load_data, 32'h0000_80FF);
    run_txn(1'b0, 3'd2, 32'h102, 32'h0, 32'h1111_1111, 0, 0);
    chk("lw_mis_lit", load_data, 32'h0);
    run_txn(1'b1, 3'd1, 32'h001, 32'hABCD, 32'h0, 0, 0);
    run_txn(1'b0, 3'd2, 32'h104, 32'h0, 32'h5555_AAAA, 0, 0);
    run_txn(1'b0, 3'd2, 32'h300, 32'h0, 32'h7777_7777, 0, 20);
    chk("timeout_ld_lit", load_data, 32'h0);
    idle(2);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom % 2 == 0) a = a & 32'hFFFF_FFFC;
      run_txn(1'($urandom % 2), 3'($urandom % 8), a, $urandom, $urandom,
              int'($urandom % 5), int'($urandom % 4));
      idle(int'($urandom % 3));
    end

    // Reset while waiting for read data; late rvalid must be ignored.
    chk_on = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstw_mem_req", 32'(mem_req), 32'd0);
    chk("rstw_stall", 32'(stall), 32'd0);
    chk("rstw_err", 32'(err), 32'd0);
    chk("rstw_mem_addr", mem_addr, 32'd0);
    chk("rstw_mem_be", 32'(mem_be), 32'd0);
    chk("rstw_mem_we", 32'(mem_we), 32'd0);
    chk("rstw_load_data", load_data, 32'd0);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("rstw_rvalid_ignored", load_data, 32'd0);
    chk("rstw_idle_req", 32'(mem_req), 32'd0);
    e_ld = '0;
    chk_on = 1'b1;
    run_txn(1'b0, 3'd2, 32'h40, 32'h0, 32'h0BAD_F00D, 0, 0);
    chk("post_rst_lw_lit", load_data, 32'h0BAD_F00D);
    idle(2);
    chk_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
